// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch T0-T2, decode in T3, per-class execute T3-T7.
// Optional macro MEM_WAIT_EN: memory states wait on mem_done; otherwise they last one cycle.
module control_sequencer #(
  parameter logic [4:0] ALU_INC = 5'd12,
  parameter logic [4:0] ALU_ADD = 5'd3
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic [31:0] IR,
  input  logic        mem_done,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic [4:0]  OpCode,
  output logic        instr_done,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_t1_first;
  logic        r_illegal;
  logic        w_set_illegal;
  logic        w_mem_ok;
  logic [4:0]  w_op;
  logic        w_rtype;
  logic        w_imm;
  logic        w_ld;
  logic        w_ldi;
  logic        w_st;
  state_t      w_ret;
  logic        w_unused_fields;

  assign w_op    = IR[31:27];
  assign w_rtype = (w_op >= 5'd3) && (w_op <= 5'd10);
  assign w_imm   = (w_op >= 5'd11) && (w_op <= 5'd13);
  assign w_ld    = (w_op == 5'd0);
  assign w_ldi   = (w_op == 5'd1);
  assign w_st    = (w_op == 5'd2);
  assign w_unused_fields = ^IR[26:0];

  // A falling run is only honoured where an instruction would re-enter T0.
  assign w_ret = run ? S_T0 : S_IDLE;

`ifdef MEM_WAIT_EN
  assign w_mem_ok = mem_done;
`else
  assign w_mem_ok = 1'b1;
`endif

  assign illegal = r_illegal;

  // State, T1 entry flag and sticky illegal flag.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= S_IDLE;
      r_t1_first <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_t1_first <= (w_next == S_T1) && (r_state != S_T1);
      r_illegal  <= r_illegal | w_set_illegal;
    end
  end

  // Next-state and strobe decode from the registered state and IR.
  always_comb begin
    w_next        = r_state;
    w_set_illegal = 1'b0;
    PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; MARin = 1'b0;
    Zin   = 1'b0; PCin    = 1'b0; MDRin  = 1'b0; IRin  = 1'b0;
    Yin   = 1'b0; Read    = 1'b0; Write  = 1'b0; Gra   = 1'b0;
    Grb   = 1'b0; Grc     = 1'b0; Rin    = 1'b0; Rout  = 1'b0;
    BAout = 1'b0; Cout    = 1'b0; OpCode = 5'd0;
    instr_done = 1'b0;
    halted     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) w_next = S_T0;
        else     w_next = S_IDLE;
      end
      S_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        Zin    = 1'b1;
        OpCode = ALU_INC;
        w_next = S_T1;
      end
      S_T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
        if (r_t1_first) begin
          Zlowout = 1'b1;
          PCin    = 1'b1;
        end else begin
          Zlowout = 1'b0;
          PCin    = 1'b0;
        end
        if (w_mem_ok) w_next = S_T2;
        else          w_next = S_T1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
        w_next = S_T3;
      end
      S_T3: begin
        if (w_rtype || w_imm) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
          w_next = S_T4;
        end else if (w_ld || w_ldi || w_st) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
          w_next = S_T4;
        end else if (w_op == 5'd30) begin
          instr_done = 1'b1;
          w_next     = w_ret;
        end else if (w_op == 5'd31) begin
          instr_done = 1'b1;
          w_next     = S_HALT;
        end else begin
          w_set_illegal = 1'b1;
          w_next        = S_HALT;
        end
      end
      S_T4: begin
        Zin = 1'b1;
        if (w_rtype) begin
          Grc = 1'b1; Rout = 1'b1; OpCode = w_op;
        end else if (w_imm) begin
          Cout = 1'b1; OpCode = w_op;
        end else begin
          Cout = 1'b1; OpCode = ALU_ADD;
        end
        w_next = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (w_ld || w_st) begin
          MARin  = 1'b1;
          w_next = S_T6;
        end else begin
          Gra = 1'b1; Rin = 1'b1; instr_done = 1'b1;
          w_next = w_ret;
        end
      end
      S_T6: begin
        MDRin = 1'b1;
        if (w_st) begin
          Gra = 1'b1; Rout = 1'b1;
          w_next = S_T7;
        end else if (w_mem_ok) begin
          Read   = 1'b1;
          w_next = S_T7;
        end else begin
          Read   = 1'b1;
          w_next = S_T6;
        end
      end
      S_T7: begin
        if (w_st) begin
          Write = 1'b1;
          if (w_mem_ok) begin
            instr_done = 1'b1;
            w_next     = w_ret;
          end else begin
            w_next = S_T7;
          end
        end else begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; instr_done = 1'b1;
          w_next = w_ret;
        end
      end
      S_HALT: begin
        halted = 1'b1;
        w_next = S_HALT;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench: a per-instruction cycle model builds the expected strobe schedule,
// one process drives inputs and compares all outputs every cycle.
module tb_control_sequencer;

  typedef struct packed {
    logic pcout, zlowout, mdrout, marin, zin, pcin, mdrin, irin, yin, read, write;
    logic gra, grb, grc, rin, rout, baout, cout;
    logic [4:0] opcode;
    logic instr_done, halted, illegal;
  } outs_t;

  typedef struct {
    bit          clr;
    bit          run;
    bit          mem;
    logic [31:0] ir;
    outs_t       exp;
    string       tag;
  } cyc_t;

`ifdef MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr, run, mem_done;
  logic [31:0] IR;
  logic PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, Read, Write;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, instr_done, halted, illegal;
  logic [4:0] OpCode;
  outs_t dut_o;

  cyc_t        sched[$];
  logic [31:0] cur_ir;
  bit          m_illegal;
  int          n_pass = 0;
  int          n_total = 0;

  control_sequencer dut (
    .clk(clk), .clr(clr), .run(run), .IR(IR), .mem_done(mem_done),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin), .Zin(Zin),
    .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Read(Read), .Write(Write),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
    .OpCode(OpCode), .instr_done(instr_done), .halted(halted), .illegal(illegal)
  );

  assign dut_o = {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, Read, Write,
                  Gra, Grb, Grc, Rin, Rout, BAout, Cout, OpCode, instr_done, halted, illegal};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic outs_t base();
    outs_t o = '0;
    o.illegal = m_illegal;
    return o;
  endfunction

  // mem_done value for a memory-state cycle: asserted only on the completing cycle.
  function automatic bit mem_for(input bit last);
    return WAIT_EN ? last : 1'b0;
  endfunction

  task automatic push(input bit c, input bit r, input bit m, input outs_t o, input string tag);
    cyc_t x;
    x.clr = c; x.run = r; x.mem = m; x.ir = cur_ir; x.exp = o; x.tag = tag;
    sched.push_back(x);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) push(1'b0, r, 1'b1, base(), "IDLE");
  endtask

  task automatic halt_cycles(input int n);
    outs_t o;
    for (int i = 0; i < n; i++) begin
      o = base(); o.halted = 1'b1;
      push(1'b0, 1'b1, 1'b1, o, "HALT");
    end
  endtask

  // Expected cycles of one instruction starting at T0; waits are extra cycles before mem_done.
  task automatic add_instr(input logic [31:0] ir, input int w1, input int w6, input int w7,
                           input bit run_after, input bit clr_t6);
    outs_t o;
    logic [4:0] op = ir[31:27];
    bit rt  = (op >= 5'd3) && (op <= 5'd10);
    bit imm = (op >= 5'd11) && (op <= 5'd13);
    bit ls  = (op <= 5'd2);
    bit mem = (op == 5'd0) || (op == 5'd2);
    int n1 = WAIT_EN ? w1 : 0;
    int n6 = WAIT_EN ? w6 : 0;
    int n7 = WAIT_EN ? w7 : 0;
    o = base(); o.pcout = 1'b1; o.marin = 1'b1; o.zin = 1'b1; o.opcode = 5'd12;
    push(1'b0, 1'b1, 1'b1, o, "T0");
    for (int i = 0; i <= n1; i++) begin
      o = base(); o.read = 1'b1; o.mdrin = 1'b1;
      if (i == 0) begin o.zlowout = 1'b1; o.pcin = 1'b1; end
      push(1'b0, 1'b1, mem_for(i == n1), o, "T1");
    end
    o = base(); o.mdrout = 1'b1; o.irin = 1'b1;
    push(1'b0, 1'b1, 1'b1, o, "T2");
    cur_ir = ir;
    o = base();
    if (rt || imm) begin
      o.grb = 1'b1; o.rout = 1'b1; o.yin = 1'b1;
    end else if (ls) begin
      o.grb = 1'b1; o.baout = 1'b1; o.yin = 1'b1;
    end else if (op == 5'd30 || op == 5'd31) begin
      o.instr_done = 1'b1;
      push(1'b0, run_after, 1'b1, o, "T3_done");
      return;
    end else begin
      push(1'b0, 1'b1, 1'b1, o, "T3_illegal");
      m_illegal = 1'b1;
      return;
    end
    push(1'b0, 1'b1, 1'b1, o, "T3");
    o = base(); o.zin = 1'b1;
    if (rt)       begin o.grc = 1'b1; o.rout = 1'b1; o.opcode = op; end
    else if (imm) begin o.cout = 1'b1; o.opcode = op; end
    else          begin o.cout = 1'b1; o.opcode = 5'd3; end
    push(1'b0, 1'b1, 1'b1, o, "T4");
    o = base(); o.zlowout = 1'b1;
    if (!mem) begin
      o.gra = 1'b1; o.rin = 1'b1; o.instr_done = 1'b1;
      push(1'b0, run_after, 1'b1, o, "T5_done");
      return;
    end
    o.marin = 1'b1;
    push(1'b0, 1'b1, 1'b1, o, "T5");
    if (op == 5'd2) begin
      o = base(); o.gra = 1'b1; o.rout = 1'b1; o.mdrin = 1'b1;
      push(1'b0, 1'b1, 1'b0, o, "T6_st");
      for (int i = 0; i <= n7; i++) begin
        o = base(); o.write = 1'b1; o.instr_done = (i == n7);
        push(1'b0, (i == n7) ? run_after : 1'b1, mem_for(i == n7), o, "T7_st");
      end
    end else begin
      for (int i = 0; i <= n6; i++) begin
        o = base(); o.read = 1'b1; o.mdrin = 1'b1;
        push(clr_t6 && (i == 0), 1'b1, mem_for(i == n6), o, "T6_ld");
        if (clr_t6) begin
          m_illegal = 1'b0;
          return;
        end
      end
      o = base(); o.mdrout = 1'b1; o.gra = 1'b1; o.rin = 1'b1; o.instr_done = 1'b1;
      push(1'b0, run_after, 1'b1, o, "T7_ld");
    end
  endtask

  initial begin
    int start;
    int reads;
    cyc_t x;
    outs_t o;
    clr = 1'b1; run = 1'b1; mem_done = 1'b1; IR = 32'hDEAD_BEEF;
    m_illegal = 1'b0;
    cur_ir = 32'hDEAD_BEEF;

    push(1'b1, 1'b1, 1'b1, base(), "reset0");
    push(1'b1, 1'b1, 1'b1, base(), "reset1");
    idle(1, 1'b1);

    start = sched.size();
    add_instr(32'h2891_8000, 0, 0, 0, 1'b1, 1'b0);
    check("model_rtype_len", sched.size() - start, 32'd6);
    check("model_rtype_t4_op", {27'd0, sched[start + 4].exp.opcode}, 32'd5);
    check("model_rtype_t0_op", {27'd0, sched[start].exp.opcode}, 32'd12);

    add_instr({5'd12, 4'd4, 4'd5, 19'd100}, 0, 0, 0, 1'b1, 1'b0);
    add_instr({5'd1, 4'd6, 4'd0, 19'd7}, 0, 0, 0, 1'b1, 1'b0);

    start = sched.size();
    add_instr({5'd0, 4'd7, 4'd1, 19'd8}, 0, 3, 0, 1'b1, 1'b0);
    check("model_ld_len", sched.size() - start, WAIT_EN ? 32'd11 : 32'd8);
    reads = 0;
    for (int i = start; i < sched.size(); i++) reads += sched[i].exp.read;
    check("model_ld_reads", reads, WAIT_EN ? 32'd5 : 32'd2);

    add_instr({5'd0, 4'd2, 4'd1, 19'd0}, 2, 0, 0, 1'b1, 1'b0);
    add_instr({5'd2, 4'd3, 4'd1, 19'd4}, 1, 0, 2, 1'b1, 1'b0);
    add_instr({5'd10, 4'd1, 4'd2, 4'd3, 15'd0}, 0, 0, 0, 1'b1, 1'b0);
    add_instr({5'd13, 4'd1, 4'd2, 19'h7FFFF}, 0, 0, 0, 1'b1, 1'b0);
    add_instr({5'd30, 27'd0}, 0, 0, 0, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);

    add_instr({5'd20, 27'd0}, 0, 0, 0, 1'b1, 1'b0);
    halt_cycles(3);
    o = base(); o.halted = 1'b1;
    push(1'b1, 1'b1, 1'b1, o, "clr_in_halt");
    m_illegal = 1'b0;
    idle(1, 1'b1);

    add_instr({5'd0, 4'd5, 4'd1, 19'd3}, 0, 2, 0, 1'b1, 1'b1);
    idle(1, 1'b0);
    idle(1, 1'b1);
    add_instr({5'd31, 27'd0}, 0, 0, 0, 1'b1, 1'b0);
    halt_cycles(4);

    while (sched.size() > 0) begin
      @(negedge clk);
      x = sched.pop_front();
      clr = x.clr; run = x.run; mem_done = x.mem; IR = x.ir;
      #1;
      check(x.tag, {6'd0, dut_o}, {6'd0, x.exp});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardware control unit that drives the Datapath control strobes in place of the hand-written state tables used in datapath benches.
- Runs the fetch sequence T0–T2, decodes IR, then runs per-class execute steps T3–T7. Returns to T0 or halts.
- Targets three-register ALU, immediate ALU, ld, ldi, st, nop and halt instructions.

Parameters:
- ALU_INC, 12: OpCode driven in T0 for PC+1.
- ALU_ADD, 3: OpCode used for address and ldi computation.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  synchronous active-high reset.
- run  in  1  level; sequencer leaves IDLE when high.
- IR  in  32  IR register contents. Fields: op=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15].
- mem_done  in  1  memory completion; sampled in memory-access states.
- PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, Read, Write  out  1 each  Datapath strobes.
- Gra, Grb, Grc, Rin, Rout, BAout, Cout  out  1 each  register-select and constant strobes.
- OpCode  out  5  ALU operation select.
- instr_done  out  1  one-cycle pulse in the final step of each instruction.
- halted  out  1  high in HALT.
- illegal  out  1  sticky; set when an undefined op is decoded.

Behaviour:
- Reset: clr high at a clock edge → state IDLE, illegal=0, and on the next cycle every output is 0 (OpCode=0). clr overrides all other inputs, including mid-instruction and during a memory wait.
- Outputs are a combinational decode of the registered state and IR. All strobes default to 0 and are asserted only in the states listed below.
- States and transitions:
  - IDLE: no strobes; → T0 when run=1.
  - T0: PCout, MARin, Zin, OpCode=ALU_INC; → T1.
  - T1: Read and MDRin asserted while waiting. Zlowout and PCin asserted only in the first T1 cycle (entry flag). Stay in T1 until mem_done=1, then → T2.
  - T2: MDRout, IRin; → T3. IR holds the new instruction from T3 on.
  - T3: decode IR.
    - op 3–10 (R-type): Grb, Rout, Yin.
    - op 11–13 (immediate): Grb, Rout, Yin.
    - op 0 (ld), 1 (ldi), 2 (st): Grb, BAout, Yin.
    - op 30 (nop): instr_done; → T0.
    - op 31 (halt): instr_done; → HALT.
    - any other op: set illegal; → HALT.
  - T4:
    - R-type: Grc, Rout, Zin, OpCode=op.
    - immediate: Cout, Zin, OpCode=op.
    - ld/ldi/st: Cout, Zin, OpCode=ALU_ADD.
  - T5:
    - R-type, immediate, ldi: Zlowout, Gra, Rin, instr_done; → T0.
    - ld/st: Zlowout, MARin; → T6.
  - T6:
    - ld: Read, MDRin; hold until mem_done=1, then → T7.
    - st: Gra, Rout, MDRin; → T7.
  - T7:
    - ld: MDRout, Gra, Rin, instr_done; → T0.
    - st: Write; hold until mem_done=1, then instr_done; → T0.
  - HALT: halted=1, no strobes. Leave only via clr.
- run dropping low is honoured only at T0 entry: the current instruction completes, then the sequencer goes to IDLE instead of T0.
- mem_done arriving in the first cycle of a wait state completes the access with zero wait cycles. mem_done outside T1/T6/T7 is ignored.
- Never assert two drivers of the bus together (PCout, Zlowout, MDRout, Rout, Cout, BAout): at most one per state.

Optional Feature:
- Macro MEM_WAIT_EN.
  - Defined: memory states wait for mem_done as described above.
  - Undefined: mem_done is ignored and T1, T6 and T7 each last exactly one cycle. Zlowout/PCin, Read/MDRin and Write are then single-cycle pulses.

Test Plan:
- clr=1 for 2 cycles, run=1, with mem_done and IR held at arbitrary values → all outputs 0 and state IDLE throughout; T0 first seen on the cycle after clr falls.
- run=1, IR=0x28918000 (and R1,R2,R3), mem_done tied 1 →
  - T0: PCout/MARin/Zin with OpCode=12.
  - T3: Grb/Rout/Yin.
  - T4: Grc/Rout/Zin with OpCode=5.
  - T5: Zlowout/Gra/Rin plus instr_done.
  - Next cycle: back in T0; 6 cycles total.
- ld with mem_done delayed 3 cycles in T6 (MEM_WAIT_EN defined) → Read and MDRin high for exactly 4 cycles; T7 MDRout/Gra/Rin; total 11 cycles including the T1 wait.
- st with MEM_WAIT_EN undefined → Write high for exactly 1 cycle in T7; instr_done coincides with it.
- IR op=20, then op=31 in a second run → illegal=1 and halted=1 after T3; after the op=31 halt, illegal=0 and halted=1; only clr clears the state.
- clr asserted during the T6 wait of ld → next cycle IDLE, all strobes 0, illegal=0.
